// File: rtl/vending_machine_multi_pkg.sv
// Shared types and coin constants for the multi-product vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELIVER = 2'd1,
    ST_CHANGE  = 2'd2
  } state_t;

  localparam logic [7:0] COIN_10  = 8'd10;
  localparam logic [7:0] COIN_20  = 8'd20;
  localparam logic [7:0] COIN_50  = 8'd50;
  localparam logic [7:0] COIN_100 = 8'd100;
  localparam logic [7:0] COIN_200 = 8'd200;

  function automatic logic is_valid_coin(input logic [7:0] c);
    return (c == COIN_10) || (c == COIN_20) || (c == COIN_50) ||
           (c == COIN_100) || (c == COIN_200);
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / dispenser bundle of the vending controller.
interface vending_machine_multi_if #(
  parameter int SEL_W    = 3,
  parameter int CREDIT_W = 10,
  parameter int STOCK_W  = 4
);
  // No handshake: every input is a level sampled on each rising edge, every
  // pulse output is high for exactly one cycle; there is no back-pressure.
  logic [7:0]          coin_in;
  logic [SEL_W-1:0]    button_in;
  logic                cancel_in;
  logic                restock_in;
  logic [SEL_W-1:0]    restock_sel;
  logic [STOCK_W-1:0]  restock_qty;
  logic [SEL_W-1:0]    beverage_out;
  logic [7:0]          change_out;
  logic                coin_reject_out;
  logic                sold_out_out;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state;

  modport master (
    output coin_in, button_in, cancel_in, restock_in, restock_sel, restock_qty,
    input  beverage_out, change_out, coin_reject_out, sold_out_out, credit, state
  );

  modport slave (
    input  coin_in, button_in, cancel_in, restock_in, restock_sel, restock_qty,
    output beverage_out, change_out, coin_reject_out, sold_out_out, credit, state
  );
endinterface

// File: rtl/vm_change_dispenser.sv
// Greedy change selection: largest real denomination not above the credit.
module vm_change_dispenser
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 10
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [7:0]          o_coin
);
  logic [31:0] w_credit;
  assign w_credit = 32'(i_credit);

  always_comb begin
    o_coin = 8'd0;
    if (w_credit >= 32'(COIN_200))      o_coin = COIN_200;
    else if (w_credit >= 32'(COIN_100)) o_coin = COIN_100;
    else if (w_credit >= 32'(COIN_50))  o_coin = COIN_50;
    else if (w_credit >= 32'(COIN_20))  o_coin = COIN_20;
    else if (w_credit >= 32'(COIN_10))  o_coin = COIN_10;
  end
endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit, per-product stock, delivery
// timing and greedy change return. All outputs come straight from flops.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 10,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_TABLE =
    {10'd150, 10'd100, 10'd70, 10'd50},
  parameter int MAX_CREDIT     = 500,
  parameter int DELIVER_CYCLES = 3,
  parameter int STOCK_W        = 4,
  parameter int INIT_STOCK     = 5
) (
  input logic clk,
  input logic rst,
  vending_machine_multi_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_PRODUCTS + 1);
  localparam int CNT_W = (DELIVER_CYCLES > 1) ? $clog2(DELIVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DELIVER_CYCLES - 1);
  localparam int SUM_W = CREDIT_W + 9;
  localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  state_t              r_state, w_next_state;
  logic [CREDIT_W-1:0] r_credit, w_next_credit;
  logic [CNT_W-1:0]    r_cnt, w_next_cnt;
  logic [SEL_W-1:0]    r_sel, w_next_sel;
  logic [STOCK_W-1:0]  r_stock [NUM_PRODUCTS];
  logic [STOCK_W:0]    w_stock_sum [NUM_PRODUCTS];
  logic [SEL_W-1:0]    r_bev, w_next_bev;
  logic [7:0]          r_change, w_next_change;
  logic                r_reject, w_next_reject;
  logic                r_sold, w_next_sold;
  logic [7:0]          w_greedy;
  logic [CREDIT_W-1:0] w_price;
  logic                w_stock_zero, w_btn_valid, w_coin_fits;
  logic                w_sale, w_sold_out, w_coin_taken;

  vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .i_credit(r_credit),
    .o_coin  (w_greedy)
  );

  assign w_btn_valid = (bus.button_in != '0) && (32'(bus.button_in) <= 32'(NUM_PRODUCTS));
  assign w_coin_fits = (SUM_W'(r_credit) + SUM_W'(bus.coin_in)) <= SUM_W'(MAX_CREDIT);

  always_comb begin
    w_price      = '0;
    w_stock_zero = 1'b0;
    for (int k = 0; k < NUM_PRODUCTS; k++) begin
      if (bus.button_in == SEL_W'(k + 1)) begin
        w_price      = PRICE_TABLE[k*CREDIT_W +: CREDIT_W];
        w_stock_zero = (r_stock[k] == '0);
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_credit = r_credit;
    w_next_cnt    = r_cnt;
    w_next_sel    = r_sel;
    w_sale        = 1'b0;
    w_sold_out    = 1'b0;
    w_coin_taken  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Cancel outranks the button, which outranks the coin slot.
        if (bus.cancel_in) begin
          if (r_credit != '0) begin
            w_next_state  = ST_CHANGE;
            w_next_credit = r_credit - CREDIT_W'(w_greedy);
          end
        end else if (bus.button_in != '0) begin
          if (w_btn_valid) begin
            if (w_stock_zero) begin
              w_sold_out = 1'b1;
            end else if (r_credit >= w_price) begin
              w_sale        = 1'b1;
              w_next_credit = r_credit - w_price;
              w_next_sel    = bus.button_in;
              w_next_cnt    = '0;
              w_next_state  = ST_DELIVER;
            end
          end
        end else if (is_valid_coin(bus.coin_in) && w_coin_fits) begin
          w_coin_taken  = 1'b1;
          w_next_credit = r_credit + CREDIT_W'(bus.coin_in);
        end
      end
      ST_DELIVER: begin
        if (r_cnt == LAST_CNT) begin
          if (r_credit != '0) begin
            w_next_state  = ST_CHANGE;
            w_next_credit = r_credit - CREDIT_W'(w_greedy);
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      ST_CHANGE: begin
        if (r_credit == '0) w_next_state = ST_IDLE;
        else                w_next_credit = r_credit - CREDIT_W'(w_greedy);
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_next_bev = '0;
    if ((w_next_state == ST_DELIVER) && (w_next_cnt == LAST_CNT)) w_next_bev = w_next_sel;
    w_next_change = (w_next_state == ST_CHANGE) ? w_greedy : 8'd0;
    w_next_reject = (bus.coin_in != 8'd0) && !w_coin_taken;
    w_next_sold   = w_sold_out;
  end

  // A sale and a restock on the same product combine before saturation.
  always_comb begin
    for (int k = 0; k < NUM_PRODUCTS; k++) begin
      w_stock_sum[k] = {1'b0, r_stock[k]}
        - ((w_sale && (w_next_sel == SEL_W'(k + 1))) ? (STOCK_W + 1)'(1) : '0)
        + ((bus.restock_in && (bus.restock_sel == SEL_W'(k + 1))) ?
           {1'b0, bus.restock_qty} : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_bev    <= '0;
      r_change <= 8'd0;
      r_reject <= 1'b0;
      r_sold   <= 1'b0;
      for (int k = 0; k < NUM_PRODUCTS; k++) r_stock[k] <= STOCK_W'(INIT_STOCK);
    end else begin
      r_state  <= w_next_state;
      r_credit <= w_next_credit;
      r_cnt    <= w_next_cnt;
      r_sel    <= w_next_sel;
      r_bev    <= w_next_bev;
      r_change <= w_next_change;
      r_reject <= w_next_reject;
      r_sold   <= w_next_sold;
      for (int k = 0; k < NUM_PRODUCTS; k++) begin
        r_stock[k] <= (w_stock_sum[k] > STOCK_MAX) ? {STOCK_W{1'b1}} : w_stock_sum[k][STOCK_W-1:0];
      end
    end
  end

  assign bus.beverage_out    = r_bev;
  assign bus.change_out      = r_change;
  assign bus.coin_reject_out = r_reject;
  assign bus.sold_out_out    = r_sold;
  assign bus.credit          = r_credit;
  assign bus.state           = r_state;
endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: cycle vectors for credit/state/pulses and a
// timed scoreboard for every beverage and change coin.
module tb_vending_machine_multi;
  localparam int D = 3;

  typedef struct packed {
    logic [7:0] coin;
    logic [2:0] btn;
    logic       cancel;
    logic       rs_en;
    logic [2:0] rs_sel;
    logic [3:0] rs_qty;
    logic [9:0] credit;
    logic [1:0] st;
    logic       rej;
    logic       sold;
    logic [2:0] bev;
    logic [7:0] chg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad = 0;
  logic [40:0] exp_q[$];
  logic [40:0] mon_got, mon_want;
  vec_t        tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  vending_machine_multi_if #(.SEL_W(3), .CREDIT_W(10), .STOCK_W(4)) bus ();
  vending_machine_multi dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic int price(input int k);
    case (k)
      1: return 50;
      2: return 70;
      3: return 100;
      default: return 150;
    endcase
  endfunction

  function automatic int greedy(input int rem);
    int denoms[5] = '{200, 100, 50, 20, 10};
    for (int i = 0; i < 5; i++) if (rem >= denoms[i]) return denoms[i];
    return 0;
  endfunction

  function automatic vec_t mk(input int coin, btn, cancel, credit, st, rej, sold, bev, chg);
    vec_t v;
    v = '0;
    v.coin = 8'(coin); v.btn = 3'(btn); v.cancel = 1'(cancel);
    v.credit = 10'(credit); v.st = 2'(st); v.rej = 1'(rej); v.sold = 1'(sold);
    v.bev = 3'(bev); v.chg = 8'(chg);
    return v;
  endfunction

  // Scoreboard: {is_change, cycle, value} must match the front of exp_q.
  always @(posedge clk) begin
    #1;
    if (bus.beverage_out != 3'd0 || bus.change_out != 8'd0) begin
      mon_got = {bus.change_out != 8'd0, cyc,
                 (bus.change_out != 8'd0) ? bus.change_out : {5'd0, bus.beverage_out}};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: unexpected kind/cycle/value=%h required=none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got != mon_want) begin
          bad++;
          $display("FAIL scoreboard: kind/cycle/value=%h required=%h", mon_got, mon_want);
        end
      end
    end
  end

  task automatic apply(input vec_t v, input string tag);
    bus.coin_in     = v.coin;
    bus.button_in   = v.btn;
    bus.cancel_in   = v.cancel;
    bus.restock_in  = v.rs_en;
    bus.restock_sel = v.rs_sel;
    bus.restock_qty = v.rs_qty;
    if (v.bev != 3'd0) exp_q.push_back({1'b0, cyc + 32'd1, 5'd0, v.bev});
    if (v.chg != 8'd0) exp_q.push_back({1'b1, cyc + 32'd1, v.chg});
    @(posedge clk);
    #1;
    total++;
    if (bus.credit !== v.credit || bus.state !== v.st ||
        bus.coin_reject_out !== v.rej || bus.sold_out_out !== v.sold) begin
      bad++;
      $display("FAIL %s @%0d: credit=%0d state=%0d rej=%b sold=%b required credit=%0d state=%0d rej=%b sold=%b",
               tag, cyc, bus.credit, bus.state, bus.coin_reject_out, bus.sold_out_out,
               v.credit, v.st, v.rej, v.sold);
    end
  endtask

  task automatic buy(input int k, input int rs_sel = 0, input int rs_qty = 0);
    int   rem;
    int   c;
    vec_t v;
    rem = 200 - price(k);
    apply(mk(200, 0, 0, 200, 0, 0, 0, 0, 0), "buy_coin");
    v = mk(0, k, 0, rem, 1, 0, 0, (D == 1) ? k : 0, 0);
    if (rs_qty != 0) begin
      v.rs_en = 1'b1; v.rs_sel = 3'(rs_sel); v.rs_qty = 4'(rs_qty);
    end
    apply(v, "buy_press");
    for (int i = 2; i <= D; i++) apply(mk(0, 0, 0, rem, 1, 0, 0, (i == D) ? k : 0, 0), "buy_deliver");
    while (rem > 0) begin
      c = greedy(rem);
      rem -= c;
      apply(mk(0, 0, 0, rem, 2, 0, 0, 0, c), "buy_change");
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "buy_idle");
  endtask

  task automatic sold_try(input int k);
    apply(mk(100, 0, 0, 100, 0, 0, 0, 0, 0), "sold_coin");
    apply(mk(0, k, 0, 100, 0, 0, 1, 0, 0), "sold_press");
    apply(mk(0, 0, 1, 0, 2, 0, 0, 0, 100), "sold_cancel");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "sold_idle");
  endtask

  task automatic restock(input int sel, input int qty, input int credit);
    vec_t v;
    v = mk(0, 0, 0, credit, 0, 0, 0, 0, 0);
    v.rs_en = 1'b1; v.rs_sel = 3'(sel); v.rs_qty = 4'(qty);
    apply(v, "restock");
  endtask

  task automatic check_reset(input string tag);
    total++;
    if (bus.state !== 2'd0 || bus.credit !== 10'd0 || bus.beverage_out !== 3'd0 ||
        bus.change_out !== 8'd0 || bus.coin_reject_out !== 1'b0 || bus.sold_out_out !== 1'b0) begin
      bad++;
      $display("FAIL %s: state=%0d credit=%0d bev=%0d chg=%0d rej=%b sold=%b required all 0",
               tag, bus.state, bus.credit, bus.beverage_out, bus.change_out,
               bus.coin_reject_out, bus.sold_out_out);
    end
  endtask

  initial begin
    bus.coin_in = 8'd0; bus.button_in = 3'd0; bus.cancel_in = 1'b0;
    bus.restock_in = 1'b0; bus.restock_sel = 3'd0; bus.restock_qty = 4'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;

    // coin, btn, cancel | credit, state, reject, sold_out, beverage, change
    tbl.push_back(mk( 50, 0, 0,  50, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 20, 0, 0,  70, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 2, 0,   0, 1, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0,   0, 1, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0,   0, 1, 0, 0, 2,   0));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(200, 0, 0, 200, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 1, 0, 150, 1, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0, 150, 1, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0, 150, 1, 0, 0, 1,   0));
    tbl.push_back(mk(  0, 0, 0,  50, 2, 0, 0, 0, 100));
    tbl.push_back(mk(  0, 0, 0,   0, 2, 0, 0, 0,  50));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 30, 0, 0,   0, 0, 1, 0, 0,   0));
    tbl.push_back(mk(255, 0, 0,   0, 0, 1, 0, 0,   0));
    tbl.push_back(mk(200, 0, 0, 200, 0, 0, 0, 0,   0));
    tbl.push_back(mk(200, 0, 0, 400, 0, 0, 0, 0,   0));
    tbl.push_back(mk(100, 0, 0, 500, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 10, 0, 0, 500, 0, 1, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 1, 300, 2, 0, 0, 0, 200));
    tbl.push_back(mk(  0, 0, 0, 100, 2, 0, 0, 0, 200));
    tbl.push_back(mk(  0, 0, 0,   0, 2, 0, 0, 0, 100));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(100, 0, 0, 100, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 2, 0,  30, 1, 0, 0, 0,   0));
    tbl.push_back(mk( 50, 0, 0,  30, 1, 1, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0,  30, 1, 0, 0, 2,   0));
    tbl.push_back(mk(  0, 0, 0,  10, 2, 0, 0, 0,  20));
    tbl.push_back(mk(  0, 0, 0,   0, 2, 0, 0, 0,  10));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 50, 0, 0,  50, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 20, 0, 0,  70, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 10, 0, 0,  80, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 2, 1,  30, 2, 0, 0, 0,  50));
    tbl.push_back(mk(  0, 0, 0,  10, 2, 0, 0, 0,  20));
    tbl.push_back(mk(  0, 0, 0,   0, 2, 0, 0, 0,  10));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 1,   0, 0, 0, 0, 0,   0));
    tbl.push_back(mk(100, 0, 0, 100, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 5, 0, 100, 0, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 4, 0, 100, 0, 0, 0, 0,   0));
    tbl.push_back(mk( 20, 1, 0,  50, 1, 1, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0,  50, 1, 0, 0, 0,   0));
    tbl.push_back(mk(  0, 0, 0,  50, 1, 0, 0, 1,   0));
    tbl.push_back(mk(  0, 0, 0,   0, 2, 0, 0, 0,  50));
    tbl.push_back(mk(  0, 0, 0,   0, 0, 0, 0, 0,   0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a refund drops the remaining credit.
    apply(mk(200, 0, 0, 200, 0, 0, 0, 0,   0), "mid_coin0");
    apply(mk(200, 0, 0, 400, 0, 0, 0, 0,   0), "mid_coin1");
    apply(mk(  0, 0, 1, 200, 2, 0, 0, 0, 200), "mid_cancel");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset("reset_mid_change");
    rst = 1'b1;

    for (int k = 1; k <= 4; k++) buy(k);
    for (int i = 0; i < 4; i++) buy(3);
    apply(mk(100, 0, 0, 100, 0, 0, 0, 0, 0), "so_coin");
    apply(mk(  0, 3, 0, 100, 0, 0, 1, 0, 0), "so_press");
    restock(3, 2, 100);
    apply(mk(  0, 3, 0,   0, 1, 0, 0, 0, 0), "rs_press");
    for (int i = 2; i <= D; i++) apply(mk(0, 0, 0, 0, 1, 0, 0, (i == D) ? 3 : 0, 0), "rs_deliver");
    apply(mk(  0, 0, 0,   0, 0, 0, 0, 0, 0), "rs_idle");

    // Sale and restock of the same product in one cycle: 1 - 1 + 3 = 3.
    buy(3, 3, 3);
    for (int i = 0; i < 3; i++) buy(3);
    sold_try(3);
    restock(0, 5, 0);
    restock(5, 5, 0);
    sold_try(3);

    restock(3, 14, 0);
    restock(3, 15, 0);
    for (int i = 0; i < 15; i++) buy(3);
    sold_try(3);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor of the two-product vending machine controller. Supports a configurable product count with per-product prices and stock counters, validates and caps inserted credit, honours a cancel request, and returns change as a greedy sequence of real coin denominations, one coin per cycle. It sits between the coin/button front-end and the dispenser actuators, and exposes credit and state for observation by the checker.

## Interface
- NUM_PRODUCTS, 4, number of selectable products (1..7)
- CREDIT_W, 10, credit register width
- PRICE_TABLE, {150,100,70,50}, packed NUM_PRODUCTS×CREDIT_W array. Entry k-1 is the price of product k. Every entry is a nonzero multiple of 10.
- MAX_CREDIT, 500, highest credit that may be held; must be < 2^CREDIT_W
- DELIVER_CYCLES, 3, cycles spent in DELIVER (≥1)
- STOCK_W, 4, per-product stock counter width
- INIT_STOCK, 5, stock loaded into every product at reset
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- coin_in  in  8  inserted coin value; 0 = none
- button_in  in  SEL_W=$clog2(NUM_PRODUCTS+1)  product select; 0 = none, k = product k
- cancel_in  in  1  request refund of all credit
- restock_in  in  1  restock strobe
- restock_sel  in  SEL_W  product to restock (1-based)
- restock_qty  in  STOCK_W  units to add
- beverage_out  out  SEL_W  delivered product, one-cycle pulse; else 0
- change_out  out  8  coin value returned this cycle; else 0
- coin_reject_out  out  1  one-cycle pulse: coin returned unaccepted
- sold_out_out  out  1  one-cycle pulse: selected product has zero stock
- credit  out  CREDIT_W  current credit
- state  out  2  IDLE=0, DELIVER=1, CHANGE=2

## Operation
- Reset (rst=0 at an edge): state IDLE, credit 0, all pulse outputs 0, every stock counter = INIT_STOCK. A reset mid-DELIVER or mid-CHANGE abandons the transaction; credit is lost.
- Valid coins: 10, 20, 50, 100, 200. An invalid value, a coin that would make credit exceed MAX_CREDIT, or any nonzero coin outside IDLE: coin_reject_out pulses and credit is unchanged.
- IDLE priority within one cycle: cancel_in > button_in > coin_in. Lower-priority inputs that cycle are ignored. An ignored coin is rejected.
- cancel_in with credit>0 → CHANGE. With credit 0 it is a no-op.
- button_in=k, with k ≤ NUM_PRODUCTS:
  - stock[k]=0 → sold_out_out pulse; credit is kept.
  - Otherwise, if credit ≥ price[k]: credit -= price[k], stock[k]--, → DELIVER.
  - Otherwise (credit < price[k]): ignored.
- button_in > NUM_PRODUCTS: ignored.
- DELIVER: counts DELIVER_CYCLES cycles. beverage_out=k during the last one. Then → CHANGE if credit>0, else IDLE.
- CHANGE: each cycle change_out = largest denomination ≤ credit, and credit is reduced by that amount. When credit reaches 0, → IDLE.
- Button and cancel are ignored outside IDLE.
- Restock is accepted in any state. Stock saturates at 2^STOCK_W−1. Restock with restock_sel 0 or > NUM_PRODUCTS is ignored. When a restock and a sale hit the same product in the same cycle, stock = sat(stock−1+qty).

## Timing
- All outputs are registered.
- Input sampled at edge t → effect visible after edge t+1 (credit, state, pulses).
- Purchase accepted at edge t: state=DELIVER during cycles t+1..t+DELIVER_CYCLES. beverage_out is asserted in cycle t+DELIVER_CYCLES. The first change coin appears in the next cycle.
- Change return: one coin per cycle, no gaps. Duration = number of greedy coins.

## Structure
- Package vending_pkg: state enum, coin denomination constants, is_valid_coin() function.
- Sub-module vm_change_dispenser: combinational greedy selection, credit in → coin value out.
- Stock counters are a per-product register array in the top module.

## Test plan
- Reset: hold rst=0 for 2 cycles → state 0, credit 0, beverage_out/change_out/pulses 0. After reset, a purchase of each product succeeds, confirming stock=5.
- Exact payment: coins 50, 20, then button 2 → credit 70, then 0. beverage_out=2 for exactly one cycle, 3 cycles after the button. No change; back to IDLE.
- Change: coin 200, button 1 → beverage_out=1, then change_out 100 then 50 on consecutive cycles. Credit 0, IDLE.
- Rejection: coin 30 → coin_reject_out pulse, credit 0. Coins 200, 200, 100, 10 → the last coin is rejected and credit stays 500. A coin inserted during DELIVER is rejected.
- Stock: with INIT_STOCK=1, buy product 3 twice with credit 200 → the second press pulses sold_out_out and credit stays 100. Restock product 3 with qty 2, press again → delivered. Restock with qty 15 onto stock 14 → stock saturates at 15.
- Cancel: credit 80, cancel_in → change_out 50, 20, 10. Cancel and button in the same cycle → cancel wins, no delivery. Reset asserted mid-CHANGE → change_out 0 and credit 0 on the next cycle.
